ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 10, RAM address width.
REQ-002 Parameter DW, default 32, RAM data width.
REQ-003 Port clock  input  1  block clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req0 / req1  input  1  access request from requester 0 / 1.
REQ-006 Port write0 / write1  input  1  1 = write access, 0 = read access.
REQ-007 Port addr0 / addr1  input  AW  requested word address.
REQ-008 Port value0 / value1  input  DW  write data.
REQ-009 Port ack0 / ack1  output  1  one-cycle completion strobe to requester 0 / 1.
REQ-010 Port rdata  output  DW  read data returned to the acked requester.
REQ-011 Port busy  output  1  high whenever state is not IDLE.
REQ-012 Port ram_addr  output  AW  address to shared RAM.
REQ-013 Port ram_write  output  1  write enable to shared RAM.
REQ-014 Port ram_value  output  DW  write data to shared RAM.
REQ-015 Port result  input  DW  RAM read data, valid the cycle after the RAM samples ram_addr.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and DONE, with every transition on the clock edge.
REQ-017 In IDLE with no request pending, the FSM SHALL remain in IDLE.
REQ-018 In IDLE with any request pending, the block SHALL select one requester, latch its write, addr and value into internal registers, record the grant, and move to ISSUE.
REQ-019 Arbitration SHALL be round-robin via a 1-bit priority pointer:
- both requests high: grant the pointer's port;
- one request high: grant that port.
REQ-020 The pointer SHALL become the non-granted port in the same cycle as each grant.
REQ-021 ram_addr and ram_value SHALL always drive the latched address and data registers.
REQ-022 ram_write SHALL be high only when the state is ISSUE, the latched op is a write, and reset is low.
REQ-023 ISSUE SHALL last exactly one cycle and then move to DONE; the RAM samples the access at the ISSUE-ending edge.
REQ-024 In DONE, the block SHALL assert the granted port's ack for exactly one cycle and then return to IDLE.
REQ-025 rdata SHALL equal result combinationally; it is meaningful only while ack is high for a read.
REQ-026 Latency SHALL be 3 cycles from request sampled in IDLE to ack, with a maximum throughput of one access per 3 cycles.
REQ-027 A requester SHALL hold req, write, addr and value stable until it sees ack, then deassert req in the following cycle; the arbiter SHALL ignore input changes outside IDLE.
REQ-028 A request arriving while busy SHALL wait and be considered at the next IDLE cycle.
REQ-029 ack0 and ack1 SHALL never be high in the same cycle, and each ack SHALL correspond to exactly one RAM access.
REQ-030 A read and a write to the same address from different ports SHALL be serialized in grant order; a read granted after a write SHALL return the written value.

Reset
REQ-031 Reset SHALL force the following values at the next edge:
- state IDLE, pointer 0;
- ack0 = ack1 = 0, busy = 0, ram_write = 0;
- latched address, data and write registers 0.
REQ-032 Reset asserted in ISSUE SHALL suppress the RAM write at that edge (per REQ-022).
REQ-033 Reset asserted in ISSUE or DONE SHALL abort the access with no ack issued.
REQ-034 Reset SHALL take priority over every other transition.

Verification
REQ-035 Reset, then req0=1, write0=1, addr0=5, value0=0xDEADBEEF -> ram_write high exactly one cycle with ram_addr=5; ack0 at cycle 3; ack1 never high.
REQ-036 After REQ-035, req1=1, write1=0, addr1=5 -> ack1 at cycle 3 with rdata=0xDEADBEEF; ram_write stays 0.
REQ-037 req0 and req1 raised together from reset, both reads, held until each ack -> port 0 acked first, port 1 acked 3 cycles later; pointer returns to 0.
REQ-038 Both ports request continuously for 12 cycles with each deasserting req for one cycle after its ack -> acks alternate 0,1,0,1 with no port served twice in a row.
REQ-039 Port 0 write to addr 7 issued, then reset pulsed during ISSUE -> no ram_write at that edge, no ack0, busy=0; a subsequent read of addr 7 returns the pre-reset contents.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Each access walks IDLE -> ISSUE -> DONE, so ack arrives on the third cycle.
module ram_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          write0,
  input  logic          write1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] value0,
  input  logic [DW-1:0] value1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_write,
  output logic [DW-1:0] ram_value,
  input  logic [DW-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic          ptr_reg, ptr_next;
  logic          grant_reg, grant_next;
  logic          write_reg, write_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] value_reg, value_next;

  logic [1:0]    req_vec;
  logic [1:0]    write_vec;
  logic [1:0]    ack_vec;
  logic [AW-1:0] addr_vec  [2];
  logic [DW-1:0] value_vec [2];
  logic          sel;

  assign req_vec      = {req1, req0};
  assign write_vec    = {write1, write0};
  assign addr_vec[0]  = addr0;
  assign addr_vec[1]  = addr1;
  assign value_vec[0] = value0;
  assign value_vec[1] = value1;

  // Contention goes to the pointer's port; otherwise the lone requester wins.
  always_comb begin
    sel = req_vec[1];
    if (req_vec == 2'b11) begin
      sel = ptr_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    write_next = write_reg;
    addr_next  = addr_reg;
    value_next = value_reg;
    case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          grant_next = sel;
          ptr_next   = ~sel;
          write_next = write_vec[sel];
          addr_next  = addr_vec[sel];
          value_next = value_vec[sel];
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      grant_reg <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      value_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      write_reg <= write_next;
      addr_reg  <= addr_next;
      value_reg <= value_next;
    end
  end

  // Gating with reset aborts an in-flight access without a stray ack.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ack
    localparam logic PORT = 1'(gi);
    assign ack_vec[gi] = (state_reg == DONE) && (grant_reg == PORT) && !reset;
  end

  assign ack0      = ack_vec[0];
  assign ack1      = ack_vec[1];
  assign busy      = (state_reg != IDLE);
  assign ram_addr  = addr_reg;
  assign ram_value = value_reg;
  assign ram_write = (state_reg == ISSUE) && write_reg && !reset;
  assign rdata     = result;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, table of single accesses,
// then contention and reset-abort sequences, all checked through a scoreboard.
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clock, reset;
  logic          req0, req1, write0, write1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] value0, value1;
  logic          ack0, ack1, busy, ram_write;
  logic [DW-1:0] rdata, ram_value, result;
  logic [AW-1:0] ram_addr;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .write0(write0), .write1(write1),
    .addr0(addr0), .addr1(addr1), .value0(value0), .value1(value1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ram_addr(ram_addr), .ram_write(ram_write), .ram_value(ram_value),
    .result(result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared RAM: write on the edge, registered read one cycle later.
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clock) begin
    if (ram_write) mem[ram_addr] <= ram_value;
    result <= mem[ram_addr];
  end

  typedef struct {
    int          port;
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          port;
    bit          wr;
    logic [9:0]  addr;
    logic [31:0] val;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  int pass_cnt = 0;
  int total_cnt = 0;
  int cycle_cnt = 0;
  int wr_seen = 0;
  logic [AW-1:0] last_wr_addr;
  logic [DW-1:0] last_wr_data;

  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic flag_fail(input string name, input longint act, input longint exp);
    total_cnt++;
    $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Output monitor: every ack must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (ram_write) begin
      wr_seen++;
      last_wr_addr = ram_addr;
      last_wr_data = ram_value;
    end
    if (ack0 || ack1) begin
      check("ack_exclusive", longint'(ack0 && ack1), 0);
      if (sb.size() == 0) begin
        flag_fail("unexpected_ack", longint'({ack1, ack0}), 0);
      end else begin
        e = sb.pop_front();
        check("ack_port", longint'(ack1), e.port);
        check("ack_cycle", cycle_cnt, e.cyc);
        if (e.rd) check("rdata", rdata, e.data);
        $display("txn ack port=%0d cycle=%0d rdata=%08h", ack1 ? 1 : 0, cycle_cnt, rdata);
      end
    end
  end

  task automatic set_port(input int port, input bit r, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] v);
    if (port == 0) begin
      req0 = r; write0 = w; addr0 = a; value0 = v;
    end else begin
      req1 = r; write1 = w; addr1 = a; value1 = v;
    end
  endtask

  task automatic wait_ack(input int port, output bit got);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if ((port == 0) ? ack0 : ack1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) flag_fail("ack_timeout", port, port);
  endtask

  task automatic do_access(input int port, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] v, input logic [DW-1:0] exp);
    int wr_before;
    bit got;
    @(posedge clock); #1;
    wr_before = wr_seen;
    set_port(port, 1'b1, wr, a, v);
    sb.push_back('{port, !wr, exp, cycle_cnt + 2});
    wait_ack(port, got);
    @(posedge clock); #1;
    set_port(port, 1'b0, 1'b0, '0, '0);
    check("ram_write_cycles", wr_seen - wr_before, wr ? 1 : 0);
    if (wr) begin
      check("ram_addr", last_wr_addr, a);
      check("ram_value", last_wr_data, v);
    end
  endtask

  // Requester that drops req for one cycle after each ack, then re-raises.
  task automatic requester(input int port, input int n, input logic [AW-1:0] a);
    bit got;
    for (int i = 0; i < n; i++) begin
      set_port(port, 1'b1, 1'b0, a, '0);
      wait_ack(port, got);
      @(posedge clock); #1;
      set_port(port, 1'b0, 1'b0, '0, '0);
      if (i < n - 1) begin
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int wr_before;

    vecs[0] = '{0, 1'b1, 10'd5,    32'hDEADBEEF, 32'h0};
    vecs[1] = '{1, 1'b0, 10'd5,    32'h0,        32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 10'd7,    32'h11111111, 32'h0};
    vecs[3] = '{0, 1'b1, 10'd0,    32'hA5A5A5A5, 32'h0};
    vecs[4] = '{1, 1'b1, 10'd1023, 32'h12345678, 32'h0};
    vecs[5] = '{0, 1'b0, 10'd1023, 32'h0,        32'h12345678};
    vecs[6] = '{0, 1'b0, 10'd0,    32'h0,        32'hA5A5A5A5};
    vecs[7] = '{1, 1'b0, 10'd7,    32'h0,        32'h11111111};

    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    do_reset();
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_ack", longint'({ack1, ack0}), 0);
    check("rst_ram_write", ram_write, 0);

    // Single accesses, including write then cross-port read of the same word.
    foreach (vecs[i]) begin
      $display("txn req port=%0d wr=%0d addr=%0d value=%08h", vecs[i].port, vecs[i].wr,
               vecs[i].addr, vecs[i].val);
      do_access(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].val, vecs[i].exp);
    end

    // Simultaneous requests from reset: port 0 first, port 1 three cycles later.
    do_reset();
    @(posedge clock); #1;
    k = cycle_cnt;
    sb.push_back('{0, 1'b1, 32'hA5A5A5A5, k + 2});
    sb.push_back('{1, 1'b1, 32'h12345678, k + 5});
    fork
      requester(0, 1, 10'd0);
      requester(1, 1, 10'd1023);
    join

    // No reset in between: pointer must be back on port 0, then strict alternation.
    @(posedge clock); #1;
    k = cycle_cnt;
    sb.push_back('{0, 1'b1, 32'hDEADBEEF, k + 2});
    sb.push_back('{1, 1'b1, 32'h11111111, k + 5});
    sb.push_back('{0, 1'b1, 32'hDEADBEEF, k + 8});
    sb.push_back('{1, 1'b1, 32'h11111111, k + 11});
    fork
      requester(0, 2, 10'd5);
      requester(1, 2, 10'd7);
    join

    // Reset during ISSUE of a write: no RAM write, no ack, registers cleared.
    @(posedge clock); #1;
    wr_before = wr_seen;
    set_port(0, 1'b1, 1'b1, 10'd7, 32'h22222222);
    @(posedge clock); #1;
    check("issue_busy", busy, 1);
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    check("rst_issue_ram_write", ram_write, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_issue_busy", busy, 0);
    check("rst_issue_ack0", ack0, 0);
    check("rst_issue_ram_addr", ram_addr, 0);
    check("rst_issue_ram_value", ram_value, 0);
    check("rst_issue_writes", wr_seen - wr_before, 0);
    do_access(0, 1'b0, 10'd7, '0, 32'h11111111);

    // Reset during DONE of a read: the ack is suppressed.
    @(posedge clock); #1;
    set_port(1, 1'b1, 1'b0, 10'd5, '0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    set_port(1, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    check("rst_done_ack1", ack1, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_done_busy", busy, 0);
    do_access(1, 1'b0, 10'd5, '0, 32'hDEADBEEF);

    repeat (3) @(posedge clock);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
